// File: rtl/reg_file_pkg.sv
// Shared types for the two-requester register file front end.
// Holds the sizing constants, FSM encoding and the latched command record.
package reg_file_pkg;

   localparam int DW = 8;
   localparam int AW = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic          owner;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } arb_cmd_t;

endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot winner from two requests and a
// preference pointer (ptr names the requester that wins a tie).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      unique case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = ptr ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares a 4x8 register file between two requesters, one transaction at a
// time, round-robin, with registered grants and read data returned per owner.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | sample requests, pick a winner, latch its command
//   ISSUE   | grant pulse; command on the rf ports, write strobe if write
//   RD_WAIT | read address held; capture rf read data at the closing edge
module reg_file_arbiter #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk_i,
   input  logic          rstn_i,

   input  logic          req0_i,
   input  logic          we0_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [DW-1:0] wdata0_i,
   output logic          gnt0_o,
   output logic          rvalid0_o,
   output logic [DW-1:0] rdata0_o,

   input  logic          req1_i,
   input  logic          we1_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wdata1_i,
   output logic          gnt1_o,
   output logic          rvalid1_o,
   output logic [DW-1:0] rdata1_o,

   output logic          rf_wren_o,
   output logic [AW-1:0] rf_wr_addr_o,
   output logic [DW-1:0] rf_wr_data_o,
   output logic [AW-1:0] rf_rd_addr_o,
   input  logic [DW-1:0] rf_rd_data_i
);
   import reg_file_pkg::*;

   arb_state_t state;
   arb_cmd_t   cmd;
   arb_cmd_t   sel_cmd;
   logic       ptr;
   logic [1:0] win;

   rr_arb2 u_rr_arb2 (
      .req ({req1_i, req0_i}),
      .ptr (ptr),
      .win (win)
   );

   always_comb begin
      sel_cmd = '0;
      if (win[1]) begin
         sel_cmd.owner = 1'b1;
         sel_cmd.we    = we1_i;
         sel_cmd.addr  = addr1_i;
         sel_cmd.wdata = wdata1_i;
      end else begin
         sel_cmd.owner = 1'b0;
         sel_cmd.we    = we0_i;
         sel_cmd.addr  = addr0_i;
         sel_cmd.wdata = wdata0_i;
      end
   end

   // The rf address/data ports follow the latched command directly, so they
   // are stable for the whole of ISSUE and RD_WAIT without extra registers.
   assign rf_wr_addr_o = cmd.addr;
   assign rf_wr_data_o = cmd.wdata;
   assign rf_rd_addr_o = cmd.addr;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         cmd       <= '0;
         gnt0_o    <= 1'b0;
         gnt1_o    <= 1'b0;
         rvalid0_o <= 1'b0;
         rvalid1_o <= 1'b0;
         rdata0_o  <= '0;
         rdata1_o  <= '0;
         rf_wren_o <= 1'b0;
      end else begin
         gnt0_o    <= 1'b0;
         gnt1_o    <= 1'b0;
         rvalid0_o <= 1'b0;
         rvalid1_o <= 1'b0;
         rf_wren_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|win) begin
                  cmd       <= sel_cmd;
                  ptr       <= win[0];
                  gnt0_o    <= win[0];
                  gnt1_o    <= win[1];
                  rf_wren_o <= sel_cmd.we;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= cmd.we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               if (cmd.owner) begin
                  rdata1_o  <= rf_rd_data_i;
                  rvalid1_o <= 1'b1;
               end else begin
                  rdata0_o  <= rf_rd_data_i;
                  rvalid0_o <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural 4x8 register file.
module tb_reg_file_arbiter;

   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic       req0_i = 1'b0, we0_i = 1'b0;
   logic [1:0] addr0_i = '0;
   logic [7:0] wdata0_i = '0;
   logic       gnt0_o, rvalid0_o;
   logic [7:0] rdata0_o;
   logic       req1_i = 1'b0, we1_i = 1'b0;
   logic [1:0] addr1_i = '0;
   logic [7:0] wdata1_i = '0;
   logic       gnt1_o, rvalid1_o;
   logic [7:0] rdata1_o;
   logic       rf_wren_o;
   logic [1:0] rf_wr_addr_o, rf_rd_addr_o;
   logic [7:0] rf_wr_data_o, rf_rd_data_i;

   logic [7:0] rf_mem [4];
   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   reg_file_arbiter #(.DW(8), .AW(2)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
      .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o),
      .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
      .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o),
      .rf_wren_o(rf_wren_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
      .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_i(rf_rd_data_i)
   );

   // Register file: synchronous write, registered read, cleared by reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
         rf_rd_data_i <= '0;
      end else begin
         if (rf_wren_o) rf_mem[rf_wr_addr_o] <= rf_wr_data_o;
         rf_rd_data_i <= rf_mem[rf_rd_addr_o];
      end
   end

   task automatic do_reset();
      rstn_i = 1'b0;
      req0_i = 1'b0;
      req1_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   // One transaction from one requester over a fixed 5-cycle window.
   task automatic run_txn(input bit who, input bit we, input logic [1:0] addr,
                          input logic [7:0] wdata,
                          output int g_lat, output int n_gnt, output int r_lat,
                          output int n_rv, output int n_other, output int n_wren,
                          output logic [7:0] rd, output logic wren_g,
                          output logic [1:0] wa_g, output logic [7:0] wd_g);
      logic own_g, own_rv, oth;
      g_lat = 0; n_gnt = 0; r_lat = 0; n_rv = 0; n_other = 0; n_wren = 0;
      rd = '0; wren_g = 1'b0; wa_g = '0; wd_g = '0;
      @(negedge clk_i);
      if (!who) begin
         req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata;
      end else begin
         req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata;
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_i);
         own_g  = who ? gnt1_o : gnt0_o;
         own_rv = who ? rvalid1_o : rvalid0_o;
         oth    = who ? (gnt0_o | rvalid0_o) : (gnt1_o | rvalid1_o);
         if (own_g) begin
            n_gnt++;
            if (g_lat == 0) begin
               g_lat = c; wren_g = rf_wren_o; wa_g = rf_wr_addr_o; wd_g = rf_wr_data_o;
            end
            // command is latched; scramble the inputs to prove it
            if (!who) begin
               req0_i = 1'b0; we0_i = ~we; addr0_i = ~addr; wdata0_i = ~wdata;
            end else begin
               req1_i = 1'b0; we1_i = ~we; addr1_i = ~addr; wdata1_i = ~wdata;
            end
         end
         if (own_rv) begin
            n_rv++;
            if (r_lat == 0) begin
               r_lat = c; rd = who ? rdata1_o : rdata0_o;
            end
         end
         if (oth) n_other++;
         if (rf_wren_o) n_wren++;
      end
      req0_i = 1'b0;
      req1_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rf_wren_o, rdata0_o, rdata1_o,
           rf_wr_addr_o, rf_wr_data_o, rf_rd_addr_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
      end
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 2'd3; wdata0_i = 8'hFF;
      @(negedge clk_i);
      checks++;
      if ({gnt0_o, rf_wren_o} !== 2'b11) begin
         failures++;
         $display("FAIL reset_pre_gnt: got gnt0/wren=%b expected 11", {gnt0_o, rf_wren_o});
      end
      #2 rstn_i = 1'b0;
      #1;
      checks++;
      if ({gnt0_o, rf_wren_o, rf_wr_addr_o, rf_wr_data_o, rf_rd_addr_o} !== '0) begin
         failures++;
         $display("FAIL reset_async: got gnt0=%b wren=%b wa=%0d wd=%h ra=%0d expected 0",
                  gnt0_o, rf_wren_o, rf_wr_addr_o, rf_wr_data_o, rf_rd_addr_o);
      end
      req0_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      checks++;
      if (rf_mem[3] !== 8'h00 || rf_wren_o !== 1'b0 || gnt0_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_write: got mem3=%h wren=%b gnt0=%b expected 00 0 0",
                  rf_mem[3], rf_wren_o, gnt0_o);
      end
   endtask

   task automatic test_write_read();
      int g, ng, r, nr, no, nw;
      logic [7:0] rd, wd;
      logic wg;
      logic [1:0] wa;
      run_txn(1'b0, 1'b1, 2'd2, 8'hA5, g, ng, r, nr, no, nw, rd, wg, wa, wd);
      checks++;
      if (g !== 1 || ng !== 1) begin
         failures++;
         $display("FAIL wr_gnt: got lat=%0d pulses=%0d expected 1 1", g, ng);
      end
      checks++;
      if ({wg, wa, wd} !== {1'b1, 2'd2, 8'hA5}) begin
         failures++;
         $display("FAIL wr_rf_port: got wren=%b wa=%0d wd=%h expected 1 2 a5", wg, wa, wd);
      end
      checks++;
      if (nw !== 1 || nr !== 0 || no !== 0) begin
         failures++;
         $display("FAIL wr_side: got wren_cycles=%0d rvalid=%0d other=%0d expected 1 0 0", nw, nr, no);
      end
      checks++;
      if (rf_mem[2] !== 8'hA5) begin
         failures++;
         $display("FAIL wr_mem: got %h expected a5", rf_mem[2]);
      end
      run_txn(1'b1, 1'b0, 2'd2, 8'h00, g, ng, r, nr, no, nw, rd, wg, wa, wd);
      checks++;
      if (g !== 1 || r !== 3 || nr !== 1) begin
         failures++;
         $display("FAIL rd_latency: got gnt=%0d rvalid=%0d pulses=%0d expected 1 3 1", g, r, nr);
      end
      checks++;
      if (rd !== 8'hA5) begin
         failures++;
         $display("FAIL rd_data1: got %h expected a5", rd);
      end
      checks++;
      if (no !== 0 || nw !== 0) begin
         failures++;
         $display("FAIL rd_side: got other=%0d wren_cycles=%0d expected 0 0", no, nw);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g [8];
      exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      do_reset();
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 2'd0; wdata0_i = 8'h5A;
      req1_i = 1'b1; we1_i = 1'b1; addr1_i = 2'd1; wdata1_i = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         checks++;
         if ({gnt1_o, gnt0_o} !== exp_g[i] || rf_wren_o !== (|exp_g[i])) begin
            failures++;
            $display("FAIL contention_cyc%0d: got gnt=%b wren=%b expected gnt=%b wren=%b",
                     i, {gnt1_o, gnt0_o}, rf_wren_o, exp_g[i], |exp_g[i]);
         end
      end
      req0_i = 1'b0;
      req1_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (rf_mem[0] !== 8'h5A || rf_mem[1] !== 8'hC3) begin
         failures++;
         $display("FAIL contention_mem: got %h %h expected 5a c3", rf_mem[0], rf_mem[1]);
      end
   endtask

   task automatic test_readback();
      int g, ng, r, nr, no, nw;
      logic [7:0] rd, wd;
      logic wg;
      logic [1:0] wa;
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 1'b1, 2'(i), vals[i], g, ng, r, nr, no, nw, rd, wg, wa, wd);
         checks++;
         if (g !== 1 || nw !== 1) begin
            failures++;
            $display("FAIL readback_wr%0d: got gnt=%0d wren_cycles=%0d expected 1 1", i, g, nw);
         end
      end
      for (int i = 3; i >= 0; i--) begin
         run_txn(1'b0, 1'b0, 2'(i), 8'h00, g, ng, r, nr, no, nw, rd, wg, wa, wd);
         checks++;
         if (rd !== vals[i] || nr !== 1 || r !== 3) begin
            failures++;
            $display("FAIL readback_rd%0d: got data=%h pulses=%0d lat=%0d expected %h 1 3",
                     i, rd, nr, r, vals[i]);
         end
      end
   endtask

   task automatic test_reset_in_rd_wait();
      int nrv, nwr, wait_c;
      @(negedge clk_i);
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 2'd1;
      @(negedge clk_i);
      checks++;
      if (gnt0_o !== 1'b1) begin
         failures++;
         $display("FAIL rdwait_pre_gnt: got gnt0=%b expected 1", gnt0_o);
      end
      req0_i = 1'b0;
      @(negedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      checks++;
      if ({rvalid0_o, rf_wren_o, rdata0_o, rf_rd_addr_o} !== '0) begin
         failures++;
         $display("FAIL rdwait_async: got rvalid0=%b wren=%b rdata0=%h ra=%0d expected 0",
                  rvalid0_o, rf_wren_o, rdata0_o, rf_rd_addr_o);
      end
      #1 rstn_i = 1'b1;
      nrv = 0; nwr = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (rvalid0_o || rvalid1_o || gnt0_o || gnt1_o) nrv++;
         if (rf_wren_o) nwr++;
      end
      checks++;
      if (nrv !== 0 || nwr !== 0 || rdata0_o !== 8'h00) begin
         failures++;
         $display("FAIL rdwait_dropped: got events=%0d wren=%0d rdata0=%h expected 0 0 00",
                  nrv, nwr, rdata0_o);
      end
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 2'd1;
      req1_i = 1'b1; we1_i = 1'b0; addr1_i = 2'd2;
      @(negedge clk_i);
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01) begin
         failures++;
         $display("FAIL rdwait_ptr: got gnt=%b expected 01", {gnt1_o, gnt0_o});
      end
      req0_i = 1'b0;
      wait_c = 0;
      while (!gnt1_o && wait_c < 10) begin
         @(negedge clk_i);
         wait_c++;
      end
      checks++;
      if (gnt1_o !== 1'b1) begin
         failures++;
         $display("FAIL rdwait_gnt1: got no gnt1 within 10 cycles, expected one");
      end
      req1_i = 1'b0;
      repeat (4) @(negedge clk_i);
   endtask

   task automatic test_unwritten();
      int g, ng, r, nr, no, nw;
      logic [7:0] rd, wd;
      logic wg;
      logic [1:0] wa;
      do_reset();
      run_txn(1'b0, 1'b0, 2'd3, 8'h00, g, ng, r, nr, no, nw, rd, wg, wa, wd);
      checks++;
      if (r !== 3 || nr !== 1 || rd !== 8'h00) begin
         failures++;
         $display("FAIL unwritten_rd: got lat=%0d pulses=%0d data=%h expected 3 1 00", r, nr, rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_readback();
      test_reset_in_rd_wait();
      test_unwritten();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
